// File: rtl/sqd_seq_tx.sv
// Serial pattern transmitter: loads a pattern word, shifts it out MSB-first with repeats and idle gaps.
// Optional define SQD_SEQ_TX_MARK_EN enables MARK_OUT, the registered bit-0 marker of each repetition.
module sqd_seq_tx #(
    parameter int   WIDTH    = 8,
    parameter int   LEN_W    = 4,
    parameter int   CNT_W    = 4,
    parameter int   GAP_W    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] PATTERN,
    input  logic [LEN_W-1:0] LEN,
    input  logic [CNT_W-1:0] REPEAT,
    input  logic [GAP_W-1:0] GAP,
    input  logic             ABORT,
    output logic             X_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             MARK_OUT
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [LEN_W-1:0] bit_q, bit_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic             x_q, x_d;
    logic             done_q, done_d;

    logic             accept;
    logic [LEN_W-1:0] len_n;

    function automatic logic pick(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] idx);
        logic [WIDTH-1:0] s;
        s = p >> idx;
        return s[0];
    endfunction

    assign LOAD_READY = (state_q == ST_IDLE) && !ABORT && !RESET;
    assign accept     = LOAD_VALID && LOAD_READY;
    assign len_n      = (LEN > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : LEN;

    // bit_q always names the pattern bit currently on X_OUT, so x_d is looked up one bit ahead.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        bit_d   = bit_q;
        gcnt_d  = gcnt_q;
        x_d     = IDLE_BIT;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pat_d = PATTERN;
                    len_d = len_n;
                    rep_d = (REPEAT == '0) ? CNT_W'(1) : REPEAT;
                    gap_d = GAP;
                    if (len_n == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                        bit_d   = len_n - LEN_W'(1);
                        x_d     = pick(PATTERN, len_n - LEN_W'(1));
                    end
                end
            end
            ST_SHIFT: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (bit_q != '0) begin
                    bit_d = bit_q - LEN_W'(1);
                    x_d   = pick(pat_q, bit_q - LEN_W'(1));
                end else if (rep_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    rep_d = rep_q - CNT_W'(1);
                    if (gap_q != '0) begin
                        state_d = ST_GAP;
                        gcnt_d  = gap_q;
                    end else begin
                        bit_d = len_q - LEN_W'(1);
                        x_d   = pick(pat_q, len_q - LEN_W'(1));
                    end
                end
            end
            ST_GAP: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (gcnt_q == GAP_W'(1)) begin
                    state_d = ST_SHIFT;
                    bit_d   = len_q - LEN_W'(1);
                    x_d     = pick(pat_q, len_q - LEN_W'(1));
                end else begin
                    gcnt_d = gcnt_q - GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            bit_q   <= '0;
            gcnt_q  <= '0;
            x_q     <= IDLE_BIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            gcnt_q  <= gcnt_d;
            x_q     <= x_d;
            done_q  <= done_d;
        end
    end

    assign X_OUT = x_q;
    assign BUSY  = (state_q != ST_IDLE);
    assign DONE  = done_q;

`ifdef SQD_SEQ_TX_MARK_EN
    logic mark_q, mark_d;

    always_comb begin
        mark_d = (state_d == ST_SHIFT) && (bit_d == '0);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mark_q <= 1'b0;
        end else begin
            mark_q <= mark_d;
        end
    end

    assign MARK_OUT = mark_q;
`else
    assign MARK_OUT = 1'b0;
`endif

endmodule

// File: tb/tb_sqd_seq_tx.sv
// Directed bench for sqd_seq_tx: expected per-cycle outputs are queued at load time and popped each cycle.
// MARK_OUT expectations follow the SQD_SEQ_TX_MARK_EN define.
module tb_sqd_seq_tx;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       LOAD_VALID;
    logic       LOAD_READY;
    logic [7:0] PATTERN;
    logic [3:0] LEN;
    logic [3:0] REPEAT;
    logic [3:0] GAP;
    logic       ABORT;
    logic       X_OUT;
    logic       BUSY;
    logic       DONE;
    logic       MARK_OUT;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic x;
        logic busy;
        logic done;
        logic mark;
    } exp_t;

    exp_t exp_q[$];

    sqd_seq_tx dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .LOAD_VALID(LOAD_VALID),
        .LOAD_READY(LOAD_READY),
        .PATTERN   (PATTERN),
        .LEN       (LEN),
        .REPEAT    (REPEAT),
        .GAP       (GAP),
        .ABORT     (ABORT),
        .X_OUT     (X_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .MARK_OUT  (MARK_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, expv);
        end
    endtask

    task automatic push(input logic x, input logic b, input logic d, input logic m);
        exp_t e;
        e.x    = x;
        e.busy = b;
        e.done = d;
        e.mark = m;
        exp_q.push_back(e);
    endtask

    // Reference stream: clamp LEN to 8, REPEAT 0 -> 1, gaps only between repetitions, then one DONE cycle.
    task automatic push_stream(input logic [7:0] pat, input int len_in, input int rep_in, input int gap_in);
        int len;
        int rep;
        len = (len_in > 8) ? 8 : len_in;
        rep = (rep_in == 0) ? 1 : rep_in;
        if (len == 0) begin
            push(1'b0, 1'b0, 1'b1, 1'b0);
        end else begin
            for (int r = 0; r < rep; r++) begin
                for (int b = len - 1; b >= 0; b--)
                    push(pat[b], 1'b1, 1'b0, b == 0);
                if (r < rep - 1)
                    for (int g = 0; g < gap_in; g++)
                        push(1'b0, 1'b1, 1'b0, 1'b0);
            end
            push(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge CLK);
        #1;
        cyc++;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
        check("x_out", X_OUT, e.x);
        check("busy", BUSY, e.busy);
        check("done", DONE, e.done);
`ifdef SQD_SEQ_TX_MARK_EN
        check("mark", MARK_OUT, e.mark);
`else
        check("mark_tied", MARK_OUT, 1'b0);
`endif
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic [3:0] rep, input logic [3:0] gap);
        PATTERN    = pat;
        LEN        = len;
        REPEAT     = rep;
        GAP        = gap;
        LOAD_VALID = 1'b1;
    endtask

    initial begin
        RESET      = 1'b1;
        LOAD_VALID = 1'b0;
        ABORT      = 1'b0;
        PATTERN    = '0;
        LEN        = '0;
        REPEAT     = '0;
        GAP        = '0;

        // Reset values
        #2;
        check("rst_x", X_OUT, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_mark", MARK_OUT, 1'b0);
        check("rst_ready", LOAD_READY, 1'b0);
        step();
        step();
        RESET = 1'b0;
        #1;
        check("ready_after_reset", LOAD_READY, 1'b1);

        // Single repetition, inputs changed after accept must be ignored
        load(8'h0B, 4'd4, 4'd1, 4'd0);
        push_stream(8'h0B, 4, 1, 0);
        step();
        LOAD_VALID = 1'b0;
        PATTERN    = 8'hFF;
        LEN        = 4'd8;
        repeat (6) step();

        // Repeats with gaps
        load(8'h05, 4'd3, 4'd3, 4'd2);
        push_stream(8'h05, 3, 3, 2);
        step();
        LOAD_VALID = 1'b0;
        repeat (15) step();

        // LEN = 0: no bits, DONE next cycle
        load(8'hFF, 4'd0, 4'd1, 4'd0);
        push_stream(8'hFF, 0, 1, 0);
        step();
        LOAD_VALID = 1'b0;
        step();

        // LEN clamp to 8 and REPEAT = 0 treated as 1
        load(8'hA5, 4'd12, 4'd0, 4'd0);
        push_stream(8'hA5, 12, 0, 0);
        step();
        LOAD_VALID = 1'b0;
        repeat (10) step();

        // Abort during the third bit
        load(8'hC3, 4'd8, 4'd2, 4'd1);
        push(1'b1, 1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        LOAD_VALID = 1'b0;
        step();
        step();
        ABORT      = 1'b1;
        LOAD_VALID = 1'b1;
        PATTERN    = 8'hFF;
        LEN        = 4'd4;
        REPEAT     = 4'd1;
        GAP        = 4'd0;
        #1;
        check("ready_abort_busy", LOAD_READY, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("ready_abort_idle", LOAD_READY, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0);
        step();
        ABORT      = 1'b0;
        LOAD_VALID = 1'b0;
        #1;
        check("ready_after_abort", LOAD_READY, 1'b1);
        repeat (2) step();

        // Back-to-back load held through the busy period
        load(8'h06, 4'd3, 4'd1, 4'd0);
        push_stream(8'h06, 3, 1, 0);
        step();
        load(8'h0D, 4'd4, 4'd1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            check("ready_while_busy", LOAD_READY, 1'b0);
            step();
        end
        check("ready_done_cycle", LOAD_READY, 1'b1);
        push_stream(8'h0D, 4, 1, 0);
        step();
        LOAD_VALID = 1'b0;
        repeat (5) step();

        // Asynchronous reset in the middle of a gap
        load(8'h05, 4'd3, 4'd2, 4'd3);
        push(1'b1, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0);
        push(1'b1, 1'b1, 1'b0, 1'b1);
        push(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        LOAD_VALID = 1'b0;
        repeat (3) step();
        #2;
        RESET = 1'b1;
        #1;
        check("async_rst_x", X_OUT, 1'b0);
        check("async_rst_busy", BUSY, 1'b0);
        check("async_rst_done", DONE, 1'b0);
        check("async_rst_mark", MARK_OUT, 1'b0);
        check("async_rst_ready", LOAD_READY, 1'b0);
        exp_q.delete();
        step();
        RESET = 1'b0;
        step();

        // Normal operation after reset, zero-gap repetitions
        load(8'h09, 4'd4, 4'd2, 4'd0);
        push_stream(8'h09, 4, 2, 0);
        step();
        LOAD_VALID = 1'b0;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
